// File: rtl/dcache_data_sched.sv
// Single-port scheduler for one D-cache data way: arbitrates refill commits, CPU stores and
// CPU loads onto one BRAM address port, and assembles refill beats into a full-line write.
module dcache_data_sched #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BEATS      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_rd_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_rd_addr,
    output logic                    cpu_rd_grant,
    output logic                    cpu_rd_valid,
    output logic [31:0]             cpu_rd_data,
    input  logic                    cpu_st_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_st_addr,
    input  logic [3:0]              cpu_st_ben,
    input  logic [31:0]             cpu_st_data,
    output logic                    cpu_st_ready,
    input  logic                    rf_start,
    input  logic [ADDR_WIDTH-1:0]   rf_addr,
    input  logic                    rf_beat_valid,
    input  logic [31:0]             rf_beat_data,
    input  logic                    rf_beat_last,
    output logic                    rf_beat_ready,
    output logic                    rf_busy,
    output logic                    rf_done,
    output logic                    rf_err,
    output logic [ADDR_WIDTH-1:0]   bram_raddr,
    output logic                    bram_re,
    output logic [ADDR_WIDTH-1:0]   bram_waddr,
    output logic                    bram_we,
    output logic                    bram_store,
    output logic                    bram_hit_write,
    output logic [3:0]              bram_byte_ben,
    output logic [31:0]             bram_din,
    output logic [32*BEATS-1:0]     bram_din_all,
    input  logic [31:0]             bram_dout
);

    typedef enum logic [1:0] {RfIdle, RfFill, RfCommit} rf_state_e;

    rf_state_e                       state_q, state_d;
    logic [ADDR_WIDTH-4:0]           line_q, line_d;
    logic [2:0]                      crit_q, crit_d;
    logic [2:0]                      cnt_q, cnt_d;
    logic [2:0]                      widx;
    logic [BEATS-1:0][31:0]          buf_q, buf_d;
    logic                            rd_valid_q;
    logic                            done_q;

    logic busy, fill, commit;
    logic st_hazard, rd_hazard;
    logic st_issue, ld_issue, commit_issue, beat_acc;

    always_comb begin
        busy         = (state_q != RfIdle);
        fill         = (state_q == RfFill);
        commit       = (state_q == RfCommit);
        st_hazard    = busy && (cpu_st_addr[ADDR_WIDTH-1:3] == line_q);
        rd_hazard    = busy && (cpu_rd_addr[ADDR_WIDTH-1:3] == line_q);
        commit_issue = !rst && commit;
        st_issue     = !rst && cpu_st_req && !commit && !st_hazard;
        // Single address port: a store issuing this cycle always displaces the load.
        ld_issue     = !rst && cpu_rd_req && !commit && !st_issue && !rd_hazard;
        beat_acc     = !rst && fill && rf_beat_valid;
        widx         = crit_q + cnt_q;
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        crit_d  = crit_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            RfIdle: begin
                if (rf_start) begin
                    line_d  = rf_addr[ADDR_WIDTH-1:3];
                    crit_d  = rf_addr[2:0];
                    cnt_d   = 3'd0;
                    state_d = RfFill;
                end
            end
            RfFill: begin
                if (rf_beat_valid) begin
                    buf_d[widx] = rf_beat_data;
                    cnt_d       = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = RfCommit;
                    end
                end
            end
            RfCommit: state_d = RfIdle;
            default:  state_d = RfIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RfIdle;
            line_q     <= '0;
            crit_q     <= 3'd0;
            cnt_q      <= 3'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            crit_q     <= crit_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= ld_issue;
            done_q     <= commit;
        end
    end

    // Line buffer carries no reset; its contents only matter once all beats have landed.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        cpu_rd_grant   = ld_issue;
        cpu_rd_valid   = !rst && rd_valid_q;
        cpu_rd_data    = bram_dout;
        cpu_st_ready   = st_issue;
        rf_beat_ready  = !rst && fill;
        rf_busy        = !rst && busy;
        rf_done        = !rst && done_q;
        rf_err         = beat_acc && (rf_beat_last != (cnt_q == 3'd7));
        bram_re        = ld_issue;
        bram_raddr     = ld_issue ? cpu_rd_addr : '0;
        bram_we        = 1'b0;
        bram_store     = 1'b0;
        bram_hit_write = 1'b0;
        bram_waddr     = '0;
        bram_byte_ben  = 4'b0000;
        bram_din       = 32'h0;
        bram_din_all   = '0;
        if (commit_issue) begin
            bram_we        = 1'b1;
            bram_hit_write = 1'b1;
            bram_waddr     = {line_q, 3'b000};
            bram_din_all   = buf_q;
        end else if (st_issue) begin
            bram_we       = 1'b1;
            bram_store    = 1'b1;
            bram_waddr    = cpu_st_addr;
            bram_byte_ben = cpu_st_ben;
            bram_din      = cpu_st_data;
        end
    end

endmodule

// File: tb/tb_dcache_data_sched.sv
// Directed bench for dcache_data_sched with a behavioural BRAM and a load-data scoreboard.
module tb_dcache_data_sched;

    logic         clk;
    logic         rst;
    logic         cpu_rd_req;
    logic [9:0]   cpu_rd_addr;
    logic         cpu_rd_grant;
    logic         cpu_rd_valid;
    logic [31:0]  cpu_rd_data;
    logic         cpu_st_req;
    logic [9:0]   cpu_st_addr;
    logic [3:0]   cpu_st_ben;
    logic [31:0]  cpu_st_data;
    logic         cpu_st_ready;
    logic         rf_start;
    logic [9:0]   rf_addr;
    logic         rf_beat_valid;
    logic [31:0]  rf_beat_data;
    logic         rf_beat_last;
    logic         rf_beat_ready;
    logic         rf_busy;
    logic         rf_done;
    logic         rf_err;
    logic [9:0]   bram_raddr;
    logic         bram_re;
    logic [9:0]   bram_waddr;
    logic         bram_we;
    logic         bram_store;
    logic         bram_hit_write;
    logic [3:0]   bram_byte_ben;
    logic [31:0]  bram_din;
    logic [255:0] bram_din_all;
    logic [31:0]  bram_dout;

    int checks   = 0;
    int failures = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  mem [1024];
    logic [255:0] exp_line;

    dcache_data_sched #(.ADDR_WIDTH(10), .BEATS(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_grant(cpu_rd_grant),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .cpu_st_req(cpu_st_req), .cpu_st_addr(cpu_st_addr), .cpu_st_ben(cpu_st_ben),
        .cpu_st_data(cpu_st_data), .cpu_st_ready(cpu_st_ready),
        .rf_start(rf_start), .rf_addr(rf_addr), .rf_beat_valid(rf_beat_valid),
        .rf_beat_data(rf_beat_data), .rf_beat_last(rf_beat_last),
        .rf_beat_ready(rf_beat_ready), .rf_busy(rf_busy), .rf_done(rf_done), .rf_err(rf_err),
        .bram_raddr(bram_raddr), .bram_re(bram_re), .bram_waddr(bram_waddr), .bram_we(bram_we),
        .bram_store(bram_store), .bram_hit_write(bram_hit_write),
        .bram_byte_ben(bram_byte_ben), .bram_din(bram_din), .bram_din_all(bram_din_all),
        .bram_dout(bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return {16'h1357, 6'b0, a};
    endfunction

    function automatic logic [31:0] dval(input int base, input int k);
        return base[31:0] + k[31:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural 1-port BRAM: 1-cycle read latency, byte-lane or full-line writes.
    always @(posedge clk) begin
        if (bram_re) bram_dout <= mem[bram_raddr];
        if (bram_we && bram_hit_write) begin
            for (int i = 0; i < 8; i++) mem[{bram_waddr[9:3], i[2:0]}] = bram_din_all[32*i +: 32];
        end else if (bram_we && bram_store) begin
            for (int b = 0; b < 4; b++)
                if (bram_byte_ben[b]) mem[bram_waddr][8*b +: 8] = bram_din[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (cpu_rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", cpu_rd_data, exp_q.pop_front());
        end
    end

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = init_word(a[9:0]);
        bram_dout = 32'h0;
        // Reset with every request asserted
        rst = 1'b1; cpu_rd_req = 1'b1; cpu_rd_addr = 10'h0AA; cpu_st_req = 1'b1;
        cpu_st_addr = 10'h0AB; cpu_st_ben = 4'hF; cpu_st_data = 32'h1111_2222;
        rf_start = 1'b1; rf_addr = 10'h0AD; rf_beat_valid = 1'b1; rf_beat_data = 32'h0;
        rf_beat_last = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ctrl", {cpu_rd_grant, cpu_rd_valid, cpu_st_ready, rf_beat_ready, rf_busy,
                         rf_done, rf_err, bram_re, bram_we, bram_store, bram_hit_write}, 0);
        chk("rst_addr", {bram_raddr, bram_waddr, bram_byte_ben, bram_din}, 0);
        chk("rst_din_all", bram_din_all, 0);
        tick();
        rst = 1'b0; cpu_rd_req = 1'b0; cpu_st_req = 1'b0; rf_start = 1'b0;
        rf_beat_valid = 1'b0; rf_beat_last = 1'b0;
        tick();

        // Refill of line 0x15, critical word 5, with loads racing it
        rf_start = 1'b1; rf_addr = 10'h0AD;
        @(negedge clk);
        chk("rf_idle_busy", rf_busy, 0);
        tick();
        rf_start = 1'b0;
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            rf_beat_valid = 1'b1; rf_beat_data = dval(32'hD0D0_0000, k);
            rf_beat_last = (k == 7);
            exp_line[32*((5 + k) % 8) +: 32] = dval(32'hD0D0_0000, k);
            cpu_rd_req = 1'b1;
            cpu_rd_addr = (k == 0) ? 10'h100 : 10'h0AA;
            @(negedge clk);
            chk("fill_ready", rf_beat_ready, 1);
            chk("fill_err", rf_err, 0);
            chk("fill_busy", rf_busy, 1);
            chk("fill_grant", cpu_rd_grant, (k == 0));
            if (k == 0) exp_q.push_back(init_word(10'h100));
            tick();
        end
        rf_beat_valid = 1'b0; rf_beat_last = 1'b0;
        @(negedge clk);
        chk("commit_we", {bram_we, bram_hit_write, bram_store}, 3'b110);
        chk("commit_waddr", bram_waddr, 10'h0A8);
        chk("commit_w5", bram_din_all[32*5 +: 32], 32'hD0D0_0000);
        chk("commit_w7", bram_din_all[32*7 +: 32], 32'hD0D0_0002);
        chk("commit_w0", bram_din_all[31:0], 32'hD0D0_0003);
        chk("commit_w4", bram_din_all[32*4 +: 32], 32'hD0D0_0007);
        chk("commit_line", bram_din_all, exp_line);
        chk("commit_stall", cpu_rd_grant, 0);
        chk("commit_done_early", rf_done, 0);
        tick();
        @(negedge clk);
        chk("done_pulse", {rf_done, rf_busy}, 2'b10);
        chk("post_commit_grant", cpu_rd_grant, 1);
        exp_q.push_back(32'hD0D0_0005);
        tick();
        cpu_rd_req = 1'b0;
        @(negedge clk);
        chk("done_once", rf_done, 0);
        tick();

        // Store and load to the same word in one cycle
        cpu_st_req = 1'b1; cpu_st_addr = 10'h123; cpu_st_ben = 4'b0011;
        cpu_st_data = 32'hDEAD_BEEF; cpu_rd_req = 1'b1; cpu_rd_addr = 10'h123;
        @(negedge clk);
        chk("st_ready", {cpu_st_ready, cpu_rd_grant}, 2'b10);
        chk("st_bram", {bram_we, bram_store, bram_hit_write, bram_waddr, bram_byte_ben},
            {3'b110, 10'h123, 4'b0011});
        chk("st_din", bram_din, 32'hDEAD_BEEF);
        tick();
        cpu_st_req = 1'b0;
        @(negedge clk);
        chk("ld_after_st", {cpu_rd_grant, bram_re, bram_raddr}, {2'b11, 10'h123});
        exp_q.push_back({16'h1357, 16'hBEEF});
        tick();
        cpu_rd_req = 1'b0;
        tick();

        // Refill with early last marker, store on refill start, stalled store mid-fill
        rf_start = 1'b1; rf_addr = 10'h040; cpu_st_req = 1'b1; cpu_st_addr = 10'h041;
        cpu_st_ben = 4'hF; cpu_st_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("start_st_ready", cpu_st_ready, 1);
        tick();
        rf_start = 1'b0; cpu_st_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rf_beat_valid = 1'b1; rf_beat_data = dval(32'hB0B0_0000, k);
            rf_beat_last = (k == 3) || (k == 7);
            exp_line[32*k +: 32] = dval(32'hB0B0_0000, k);
            cpu_st_req = (k == 4); cpu_st_addr = 10'h045;
            rf_start = (k == 4); rf_addr = 10'h300;
            @(negedge clk);
            chk("err_pulse", rf_err, (k == 3));
            if (k == 4) chk("fill_st_stall", cpu_st_ready, 0);
            tick();
        end
        rf_beat_valid = 1'b0; rf_beat_last = 1'b0; cpu_st_req = 1'b0; rf_start = 1'b0;
        @(negedge clk);
        chk("commit2", {bram_hit_write, bram_waddr}, {1'b1, 10'h040});
        chk("commit2_line", bram_din_all, exp_line);
        tick();
        cpu_rd_req = 1'b1; cpu_rd_addr = 10'h041;
        @(negedge clk);
        chk("done2", {rf_done, cpu_rd_grant}, 2'b11);
        exp_q.push_back(32'hB0B0_0001);
        tick();
        cpu_rd_req = 1'b0;
        @(negedge clk);
        chk("no_restart", rf_busy, 0);
        tick();

        // Reset in the middle of a refill
        rf_start = 1'b1; rf_addr = 10'h200;
        tick();
        rf_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rf_beat_valid = 1'b1; rf_beat_data = dval(32'hE0E0_0000, k); rf_beat_last = 1'b0;
            cpu_rd_req = (k == 4); cpu_rd_addr = 10'h300;
            @(negedge clk);
            if (k == 4) chk("pre_rst_grant", cpu_rd_grant, 1);
            tick();
        end
        rst = 1'b1; rf_beat_valid = 1'b0; cpu_rd_req = 1'b0;
        @(negedge clk);
        chk("midrst_out", {cpu_rd_valid, rf_busy, rf_done, bram_we, bram_hit_write}, 0);
        tick();
        rst = 1'b0; rf_beat_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("after_rst", {rf_beat_ready, rf_busy, rf_done, bram_hit_write, cpu_rd_valid}, 0);
            tick();
        end
        rf_beat_valid = 1'b0;
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
